// File: rtl/hazard_md_ctrl.sv
// Hazard detection and HI/LO multiply/divide sequencing for the five-stage core.
// All state advances on the falling edge of Clk, in step with the pipeline registers.
module hazard_md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  Rs_D,
    input  logic [4:0]  Rt_D,
    input  logic [1:0]  Tuse_Rs_D,
    input  logic [1:0]  Tuse_Rt_D,
    input  logic        UseMd_D,
    input  logic [4:0]  WriteReg_E,
    input  logic [4:0]  WriteReg_M,
    input  logic        RegWrite_E,
    input  logic        RegWrite_M,
    input  logic [1:0]  Tnew_E,
    input  logic [1:0]  Tnew_M,
    input  logic        Start_E,
    input  logic        IsDiv_E,
    output logic        Stall,
    output logic        Flush_E,
    output logic        Busy,
    output logic        MdDone,
    output logic [15:0] StallCnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [15:0]      STALL_MAX = 16'hFFFF;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_done_q, md_done_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic rs_haz;
    logic rt_haz;
    logic md_haz;

    // A source stalls only if a producer in E or M will not have its value
    // ready by the time this instruction needs it; $0 is hard-wired zero.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic       rw_e,
        input logic [4:0] wr_e,
        input logic [1:0] tnew_e,
        input logic       rw_m,
        input logic [4:0] wr_m,
        input logic [1:0] tnew_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = rw_e && (wr_e == src) && (tnew_e > tuse);
        hit_m = rw_m && (wr_m == src) && (tnew_m > tuse);
        return (src != 5'd0) && (hit_e || hit_m);
    endfunction

    always_comb begin
        rs_haz = src_hazard(Rs_D, Tuse_Rs_D, RegWrite_E, WriteReg_E, Tnew_E,
                            RegWrite_M, WriteReg_M, Tnew_M);
        rt_haz = src_hazard(Rt_D, Tuse_Rt_D, RegWrite_E, WriteReg_E, Tnew_E,
                            RegWrite_M, WriteReg_M, Tnew_M);
        // Start_E counts as busy so a HI/LO user directly behind a starting
        // mult/div is held before the unit has even registered the start.
        md_haz = UseMd_D && ((state_q == ST_BUSY) || Start_E);
    end

    assign Stall    = rs_haz || rt_haz || md_haz;
    assign Flush_E  = Stall;
    assign Busy     = (state_q == ST_BUSY);
    assign MdDone   = md_done_q;
    assign StallCnt = stall_cnt_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_done_d   = 1'b0;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (Start_E) begin
                    state_d = ST_BUSY;
                    cnt_d   = IsDiv_E ? DIV_LOAD : MULT_LOAD;
                end
            end
            ST_BUSY: begin
                // A Start_E seen here cannot be legal and is dropped.
                if (cnt_q == CNT_ONE) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    md_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (Stall && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(negedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            md_done_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_done_q   <= md_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
